flags: RTL and testbench



---
 rtl/flags.sv | 33 +++
 tb/tb_flags.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flags.sv
// flags: two-bit condition-flag register for the Nibbler 4-bit CPU.
// Captures the ALU's active-low carry (notC) and zero (notZ) on every
// rising clock edge. The values are held for the decoder and the microcode
// sequencer, which use them for conditional jumps.
//
// The polarity is kept as-is. A stored 0 means that flag is set. There is
// no enable, so the register reloads on every cycle. A synchronous reset
// loads RESET_VALUE and wins over the load.
//
// flagsOut comes straight from flip-flops. No combinational path runs from
// any input to the output, so the decoder always sees a value that is
// stable for one whole cycle.

module flags #(
  parameter logic [1:0] RESET_VALUE = 2'b00  // bit order matches flagsOut
) (
  input  logic       notC,      // active-low carry from ALU
  input  logic       notZ,      // active-low zero from ALU
  input  logic       reset,     // synchronous, active-high
  input  logic       clk,
  output logic [1:0] flagsOut   // [1] = stored notC, [0] = stored notZ
);

  // Load both flags every edge; reset takes priority over the load
  always_ff @(posedge clk) begin
    if (reset) begin
      flagsOut <= RESET_VALUE;
    end else begin
      flagsOut <= {notC, notZ};
    end
  end

endmodule

// File: tb/tb_flags.sv
// tb_flags: directed self-checking bench for the flags register.
// The main instance uses the default RESET_VALUE. A second instance uses
// RESET_VALUE = 2'b11 and shares the flag inputs but has its own reset.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge.

module tb_flags;

  logic       clk;
  logic       reset;
  logic       reset2;
  logic       notC;
  logic       notZ;
  logic [1:0] flags_out;
  logic [1:0] flags_out2;

  int checks;
  int errors;

  flags dut (
    .notC     (notC),
    .notZ     (notZ),
    .reset    (reset),
    .clk      (clk),
    .flagsOut (flags_out)
  );

  flags #(.RESET_VALUE(2'b11)) dut2 (
    .notC     (notC),
    .notZ     (notZ),
    .reset    (reset2),
    .clk      (clk),
    .flagsOut (flags_out2)
  );

  // clock / reset block: 10-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance past the next rising edge and settle for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    reset2 = 1'b1;
    notC   = 1'b1;
    notZ   = 1'b1;
    step();
    checks++;
    if (flags_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_default: got %b expected %b", flags_out, 2'b00);
    end
    checks++;
    if (flags_out2 !== 2'b11) begin
      errors++;
      $display("FAIL reset_param11: got %b expected %b", flags_out2, 2'b11);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    reset = 1'b0;
    notC  = 1'b1;
    notZ  = 1'b0;
    step();
    checks++;
    if (flags_out !== 2'b10) begin
      errors++;
      $display("FAIL capture_10: got %b expected %b", flags_out, 2'b10);
    end
    @(negedge clk);
    notZ = 1'b1;
    step();
    checks++;
    if (flags_out !== 2'b11) begin
      errors++;
      $display("FAIL capture_11: got %b expected %b", flags_out, 2'b11);
    end
  endtask

  task automatic test_latency();
    // notC drops midway between edges; output must hold until next edge
    @(negedge clk);
    notC = 1'b0;
    #1;
    checks++;
    if (flags_out !== 2'b11) begin
      errors++;
      $display("FAIL latency_hold: got %b expected %b", flags_out, 2'b11);
    end
    step();
    checks++;
    if (flags_out !== 2'b01) begin
      errors++;
      $display("FAIL latency_load: got %b expected %b", flags_out, 2'b01);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    notC  = 1'b1;
    notZ  = 1'b1;
    reset = 1'b1;
    step();
    checks++;
    if (flags_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_priority: got %b expected %b", flags_out, 2'b00);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (flags_out !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", flags_out, 2'b11);
    end
  endtask

  task automatic test_short_reset();
    // 1-unit pulse from t=neg+2 to neg+3; it never covers a rising edge
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (flags_out !== 2'b11) begin
      errors++;
      $display("FAIL short_reset_now: got %b expected %b", flags_out, 2'b11);
    end
    step();
    checks++;
    if (flags_out !== 2'b11) begin
      errors++;
      $display("FAIL short_reset_edge: got %b expected %b", flags_out, 2'b11);
    end
  endtask

  task automatic test_independent();
    // walk all input pairs; each bit must follow only its own input
    logic [1:0] vec [4];
    vec[0] = 2'b01;
    vec[1] = 2'b00;
    vec[2] = 2'b10;
    vec[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      notC = vec[i][1];
      notZ = vec[i][0];
      step();
      checks++;
      if (flags_out !== vec[i]) begin
        errors++;
        $display("FAIL independent_%0d: got %b expected %b", i, flags_out, vec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // a new value every cycle, each visible exactly one edge later
    logic [1:0] vec [6];
    vec[0] = 2'b00;
    vec[1] = 2'b11;
    vec[2] = 2'b01;
    vec[3] = 2'b10;
    vec[4] = 2'b00;
    vec[5] = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      notC = vec[i][1];
      notZ = vec[i][0];
      step();
      checks++;
      if (flags_out !== vec[i]) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %b expected %b", i, flags_out, vec[i]);
      end
    end
  endtask

  task automatic test_param();
    // dut2 has been in reset all along and must still show its reset value
    checks++;
    if (flags_out2 !== 2'b11) begin
      errors++;
      $display("FAIL param_held: got %b expected %b", flags_out2, 2'b11);
    end
    @(negedge clk);
    reset2 = 1'b0;
    notC   = 1'b0;
    notZ   = 1'b0;
    step();
    checks++;
    if (flags_out2 !== 2'b00) begin
      errors++;
      $display("FAIL param_load00: got %b expected %b", flags_out2, 2'b00);
    end
    @(negedge clk);
    reset2 = 1'b1;
    step();
    checks++;
    if (flags_out2 !== 2'b11) begin
      errors++;
      $display("FAIL param_rereset: got %b expected %b", flags_out2, 2'b11);
    end
    checks++;
    if (flags_out !== 2'b00) begin
      errors++;
      $display("FAIL param_isolation: got %b expected %b", flags_out, 2'b00);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    reset2 = 1'b1;
    notC   = 1'b1;
    notZ   = 1'b1;
    test_reset();
    test_capture();
    test_latency();
    test_reset_priority();
    test_short_reset();
    test_independent();
    test_back_to_back();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
